// File: rtl/dm633_shifter.sv
// ---------------------------------------------------------------------------------------------
// dm633_shifter
//
// Frame reader and serial transmitter for a DM633 LED driver chain. On request it walks every
// channel of the framebuffer (highest index first), reads each 12-bit PWM word over the
// framebuffer's one-cycle-latency read port, shifts it MSB-first onto DAI/DCK and finally pulses
// LAT once the whole chain holds the new frame.
//
// Optional feature (compile-time macro):
//   DM633_AUTOREFRESH_EN  defined  : IDLE starts a new frame every time (continuous refresh),
//                                    i_start is ignored.
//                         undefined: a frame starts only on i_start while IDLE.
//
// Ports:
//   i_clk    system clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   i_start  frame request, sampled only in IDLE
//   o_busy   high while a frame is in progress (FETCH through LATCH)
//   o_done   one-cycle pulse after the latch pulse of every frame
//   o_ren    framebuffer read enable
//   o_raddr  framebuffer read address (holds its value outside FETCH)
//   i_rdata  framebuffer read data, valid the cycle after o_ren
//   o_dck    DM633 shift clock
//   o_dai    DM633 serial data (holds its value outside SHIFT)
//   o_lat    DM633 latch
//
// All outputs come straight from flops: each one is computed from the next state and registered
// together with it, so outputs line up with the state they belong to.
// ---------------------------------------------------------------------------------------------
module dm633_shifter #(
    parameter int unsigned c_ledboards = 30,
    parameter int unsigned c_channels  = c_ledboards * 32,
    parameter int unsigned c_addr_w    = $clog2(c_channels),
    parameter int unsigned c_bps       = 12,
    parameter int unsigned c_clkdiv    = 4,
    parameter int unsigned c_lat_w     = 4
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_ren,
    output logic [c_addr_w-1:0] o_raddr,
    input  logic [c_bps-1:0]    i_rdata,
    output logic                o_dck,
    output logic                o_dai,
    output logic                o_lat
);

    // Counter widths, kept at least one bit wide for degenerate parameter values.
    localparam int unsigned c_bit_w = (c_bps > 1)    ? $clog2(c_bps)    : 1;
    localparam int unsigned c_div_w = (c_clkdiv > 1) ? $clog2(c_clkdiv) : 1;
    localparam int unsigned c_lcw   = (c_lat_w > 1)  ? $clog2(c_lat_w)  : 1;

    localparam logic [c_addr_w-1:0] c_last_ch = c_addr_w'(c_channels - 1);
    localparam logic [c_bit_w-1:0]  c_bit_top = c_bit_w'(c_bps - 1);
    localparam logic [c_div_w-1:0]  c_div_top = c_div_w'(c_clkdiv - 1);
    localparam logic [c_lcw-1:0]    c_lat_top = c_lcw'(c_lat_w - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StShift,
        StLatch,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [c_addr_w-1:0] index_q, index_d;     // channel currently being transferred
    logic [c_bit_w-1:0]  bit_q, bit_d;         // bits left in the word after the current one
    logic [c_div_w-1:0]  div_q, div_d;         // i_clk cycles spent in the current DCK phase
    logic                phase_q, phase_d;     // 0: DCK low phase, 1: DCK high phase
    logic [c_bps-1:0]    shreg_q, shreg_d;     // word being shifted, current bit at the MSB
    logic [c_lcw-1:0]    lat_cnt_q, lat_cnt_d; // cycles of o_lat already driven

    logic                busy_d;
    logic                done_d;
    logic                ren_d;
    logic [c_addr_w-1:0] raddr_d;
    logic                dck_d;
    logic                dai_d;
    logic                lat_d;

    logic start_req;

`ifdef DM633_AUTOREFRESH_EN
    // Continuous refresh: a new frame begins on every IDLE cycle.
    logic unused_start;
    assign unused_start = i_start;
    assign start_req    = 1'b1;
`else
    assign start_req    = i_start;
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        bit_d     = bit_q;
        div_d     = div_q;
        phase_d   = phase_q;
        shreg_d   = shreg_q;
        lat_cnt_d = lat_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (start_req) begin
                    state_d = StFetch;
                    index_d = c_last_ch;
                end
            end

            StFetch: begin
                state_d = StLoad;
            end

            // Read data for the address issued in FETCH is valid now.
            StLoad: begin
                shreg_d = i_rdata;
                bit_d   = c_bit_top;
                div_d   = '0;
                phase_d = 1'b0;
                state_d = StShift;
            end

            StShift: begin
                if (div_q == c_div_top) begin
                    div_d = '0;
                    if (!phase_q) begin
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        if (bit_q == '0) begin
                            // Word finished; do not shift so o_dai keeps the last bit.
                            if (index_q == '0) begin
                                state_d   = StLatch;
                                lat_cnt_d = '0;
                            end else begin
                                index_d = index_q - 1'b1;
                                state_d = StFetch;
                            end
                        end else begin
                            bit_d   = bit_q - 1'b1;
                            shreg_d = shreg_q << 1;
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            StLatch: begin
                if (lat_cnt_q == c_lat_top) begin
                    state_d = StDone;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output next values, derived from the next state so that the
    // registered outputs are aligned with the state register.
    // ------------------------------------------------------------------
    always_comb begin
        busy_d  = (state_d == StFetch) || (state_d == StLoad) ||
                  (state_d == StShift) || (state_d == StLatch);
        done_d  = (state_d == StDone);
        ren_d   = (state_d == StFetch);
        raddr_d = ren_d ? index_d : o_raddr;
        dck_d   = (state_d == StShift) && phase_d;
        dai_d   = (state_d == StShift) ? shreg_d[c_bps-1] : o_dai;
        lat_d   = (state_d == StLatch);
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            index_q   <= '0;
            bit_q     <= '0;
            div_q     <= '0;
            phase_q   <= 1'b0;
            shreg_q   <= '0;
            lat_cnt_q <= '0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
            o_ren     <= 1'b0;
            o_raddr   <= '0;
            o_dck     <= 1'b0;
            o_dai     <= 1'b0;
            o_lat     <= 1'b0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            bit_q     <= bit_d;
            div_q     <= div_d;
            phase_q   <= phase_d;
            shreg_q   <= shreg_d;
            lat_cnt_q <= lat_cnt_d;
            o_busy    <= busy_d;
            o_done    <= done_d;
            o_ren     <= ren_d;
            o_raddr   <= raddr_d;
            o_dck     <= dck_d;
            o_dai     <= dai_d;
            o_lat     <= lat_d;
        end
    end

endmodule

// File: tb/tb_dm633_shifter.sv
// ---------------------------------------------------------------------------------------------
// tb_dm633_shifter
//
// Bench for dm633_shifter with 1 ledboard (32 channels), c_clkdiv=1, c_lat_w=2.
// Stimulus pushes expected read addresses, shifted words and frame lengths into queues; a
// monitor decodes the DCK/DAI/LAT/REN/DONE pins and pops/compares whenever the DUT presents
// an output. Define DM633_AUTOREFRESH_EN to exercise the continuous-refresh build.
// ---------------------------------------------------------------------------------------------
module tb_dm633_shifter;

    localparam int unsigned c_ledboards = 1;
    localparam int unsigned c_channels  = c_ledboards * 32;
    localparam int unsigned c_addr_w    = $clog2(c_channels);
    localparam int unsigned c_bps       = 12;
    localparam int unsigned c_clkdiv    = 1;
    localparam int unsigned c_lat_w     = 2;

    // 32 * (2 + 2*12*1) + 2
    localparam int c_frame_len = 834;
    localparam int c_rises     = 384;
    localparam int c_period    = 836;

    logic                i_clk;
    logic                i_rst_n;
    logic                i_start;
    logic                o_busy;
    logic                o_done;
    logic                o_ren;
    logic [c_addr_w-1:0] o_raddr;
    logic [c_bps-1:0]    i_rdata = '0;
    logic                o_dck;
    logic                o_dai;
    logic                o_lat;

    dm633_shifter #(
        .c_ledboards (c_ledboards),
        .c_channels  (c_channels),
        .c_addr_w    (c_addr_w),
        .c_bps       (c_bps),
        .c_clkdiv    (c_clkdiv),
        .c_lat_w     (c_lat_w)
    ) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_start (i_start),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_ren   (o_ren),
        .o_raddr (o_raddr),
        .i_rdata (i_rdata),
        .o_dck   (o_dck),
        .o_dai   (o_dai),
        .o_lat   (o_lat)
    );

    // Framebuffer model: synchronous read, one cycle latency.
    logic [c_bps-1:0] mem [c_channels];

    always @(posedge i_clk) begin
        if (o_ren) i_rdata <= mem[o_raddr];
    end

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    int cyc = 0;
    initial forever begin
        @(posedge i_clk);
        cyc++;
    end

    int checks = 0;
    int errors = 0;

    int exp_addr_q[$];
    int exp_word_q[$];
    int exp_len_q[$];

    int done_cnt  = 0;
    int lat_total = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs_zero(input string name);
        check(name, int'({o_busy, o_done, o_ren, o_raddr, o_dck, o_dai, o_lat}), 0);
    endtask

    // ------------------------------------------------------------------
    // Monitor: decodes pins on the falling edge, compares against queues.
    // ------------------------------------------------------------------
    initial begin : monitor
        logic            dck_prev;
        logic            lat_prev;
        logic [c_bps-1:0] word_acc;
        int              bit_n;
        int              busy_len;
        int              rises;
        int              lat_len;
        int              lat_pulses;
        dck_prev = 1'b0; lat_prev = 1'b0; word_acc = '0;
        bit_n = 0; busy_len = 0; rises = 0; lat_len = 0; lat_pulses = 0;
        forever begin
            @(negedge i_clk);
            if (!i_rst_n) begin
                dck_prev = 1'b0; lat_prev = 1'b0; word_acc = '0;
                bit_n = 0; busy_len = 0; rises = 0; lat_len = 0; lat_pulses = 0;
            end else begin
                if (o_busy) busy_len++;

                if (o_dck && !dck_prev) begin
                    rises++;
                    word_acc = {word_acc[c_bps-2:0], o_dai};
                    bit_n++;
                    if (bit_n == c_bps) begin
                        bit_n = 0;
                        if (exp_word_q.size() == 0) check("word_unexpected", int'(word_acc), -1);
                        else check("word", int'(word_acc), exp_word_q.pop_front());
                    end
                end
                dck_prev = o_dck;

                if (o_ren) begin
                    if (exp_addr_q.size() == 0) check("raddr_unexpected", int'(o_raddr), -1);
                    else check("raddr", int'(o_raddr), exp_addr_q.pop_front());
                end

                if (o_lat) begin
                    lat_len++;
                end else if (lat_prev) begin
                    lat_pulses++;
                    lat_total++;
                    check("lat_width", lat_len, c_lat_w);
                    lat_len = 0;
                end
                lat_prev = o_lat;

                if (o_done) begin
                    if (exp_len_q.size() == 0) check("done_unexpected", busy_len, -1);
                    else check("frame_len", busy_len, exp_len_q.pop_front());
                    check("dck_rises", rises, c_rises);
                    check("lat_pulses", lat_pulses, 1);
                    check("done_idle_busy", int'(o_busy), 0);
                    done_cnt++;
                    busy_len = 0; rises = 0; lat_pulses = 0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic clear_mem();
        for (int i = 0; i < c_channels; i++) mem[i] = '0;
    endtask

    // Expected frame: channels descending; the shifted word is the stored word.
    task automatic push_frame();
        for (int ch = c_channels - 1; ch >= 0; ch--) begin
            exp_addr_q.push_back(ch);
            exp_word_q.push_back(int'(mem[ch]));
        end
        exp_len_q.push_back(c_frame_len);
    endtask

    task automatic pulse_start();
        @(posedge i_clk); #1 i_start = 1'b1;
        @(posedge i_clk); #1 i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int base;
        int n;
        base = done_cnt;
        n = 0;
        while (done_cnt == base && n < budget) begin
            @(posedge i_clk);
            n++;
        end
        check(name, int'(done_cnt != base), 1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    initial begin
        int t0;
        int t1;
        int n;
        int bad;
        int done_before;
        int lat_before;

        i_rst_n = 1'b0;
        i_start = 1'b0;
        clear_mem();
        #1;
        check_outputs_zero("reset_outputs");
        repeat (3) @(posedge i_clk);

`ifdef DM633_AUTOREFRESH_EN
        // Continuous refresh with i_start tied low.
        mem[5]  = 12'h5A5;
        mem[20] = 12'h0F0;
        push_frame();
        push_frame();
        push_frame();
        @(negedge i_clk) i_rst_n = 1'b1;
        @(negedge i_clk);
        check("auto_first_busy", int'(o_busy), 1);
        check("auto_first_ren", int'(o_ren), 1);
        wait_done(1000, "auto_done1");
        t0 = cyc;
        wait_done(1000, "auto_done2");
        t1 = cyc;
        check("auto_period1", t1 - t0, c_period);
        wait_done(1000, "auto_done3");
        check("auto_period2", cyc - t1, c_period);
        #1 i_rst_n = 1'b0;
        #1 check_outputs_zero("auto_stop_reset");
        repeat (2) @(posedge i_clk);
`else
        @(negedge i_clk) i_rst_n = 1'b1;

        // Idle with i_start low: nothing moves.
        bad = 0;
        repeat (50) begin
            @(negedge i_clk);
            if ({o_busy, o_done, o_ren, o_raddr, o_dck, o_dai, o_lat} != '0) bad++;
        end
        check("idle_quiet_cycles", bad, 0);

        // Frame 1: only channel 31 non-zero.
        clear_mem();
        mem[31] = 12'hC00;
        push_frame();
        pulse_start();
        @(negedge i_clk);
        check("busy_after_start", int'(o_busy), 1);
        check("first_raddr", int'(o_raddr), 31);
        wait_done(1000, "frame1_done");

        // Frame 2: assorted patterns, including ch1=1 (shifts as 000000000001).
        clear_mem();
        mem[0]  = 12'hFFF;
        mem[1]  = 12'h001;
        mem[17] = 12'hA5A;
        mem[30] = 12'h800;
        mem[31] = 12'h123;
        push_frame();
        pulse_start();
        wait_done(1000, "frame2_done");
        check("raddr_holds_last", int'(o_raddr), 0);

        // i_start held high: one frame, then restart on the first IDLE cycle after DONE.
        clear_mem();
        mem[8] = 12'h3C3;
        push_frame();
        push_frame();
        @(posedge i_clk); #1 i_start = 1'b1;
        wait_done(1000, "hold_frame1_done");
        @(negedge i_clk);
        check("hold_idle_gap_busy", int'(o_busy), 0);
        check("hold_idle_gap_ren", int'(o_ren), 0);
        @(negedge i_clk);
        check("hold_restart_busy", int'(o_busy), 1);
        check("hold_restart_ren", int'(o_ren), 1);
        i_start = 1'b0;
        wait_done(1000, "hold_frame2_done");

        // Reset mid-frame at cycle 400.
        clear_mem();
        mem[31] = 12'hFFF;
        mem[0]  = 12'hFFF;
        push_frame();
        pulse_start();
        n = 0;
        while (!o_busy && n < 10) begin
            @(negedge i_clk);
            n++;
        end
        check("abort_busy_seen", int'(o_busy), 1);
        repeat (400) @(posedge i_clk);
        done_before = done_cnt;
        lat_before  = lat_total;
        #1 i_rst_n = 1'b0;
        #1 check_outputs_zero("abort_outputs");
        exp_addr_q.delete();
        exp_word_q.delete();
        exp_len_q.delete();
        repeat (3) @(negedge i_clk);
        check_outputs_zero("abort_held");
        i_rst_n = 1'b1;
        repeat (20) @(negedge i_clk);
        check("abort_no_done", done_cnt, done_before);
        check("abort_no_lat", lat_total, lat_before);
        push_frame();
        pulse_start();
        wait_done(1000, "after_abort_done");
        repeat (5) @(negedge i_clk);
`endif

        check("left_addr", exp_addr_q.size(), 0);
        check("left_words", exp_word_q.size(), 0);
        check("left_frames", exp_len_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dm633_shifter.md
# dm633_shifter

Frame reader and serial transmitter for the DM633 LED driver chain. On request it reads every channel out of the framebuffer over that block's synchronous read port, serialises each 12-bit PWM value MSB-first onto the DM633 data/clock pins, and pulses the latch once the whole chain is loaded. It sits between the framebuffer's read port and the FPGA pins driving the ledboards.

## Interface
- c_ledboards, 30, number of ledboards in the chain (two DM633s, 32 channels each)
- c_channels, c_ledboards*32, total channel count
- c_addr_w, $clog2(c_channels), framebuffer address width
- c_bps, 12, bits per channel
- c_clkdiv, 4, i_clk cycles per DCK half-period (≥1)
- c_lat_w, 4, i_clk cycles o_lat is held high (≥1)

- i_clk  in  1  system clock; all logic on its rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_start  in  1  frame request; sampled only in IDLE
- o_busy  out  1  high from FETCH through LATCH
- o_done  out  1  one-cycle pulse when a frame completes
- o_ren  out  1  framebuffer read enable
- o_raddr  out  c_addr_w  framebuffer read address
- i_rdata  in  c_bps  framebuffer read data, valid the cycle after o_ren
- o_dck  out  1  DM633 shift clock
- o_dai  out  1  DM633 serial data
- o_lat  out  1  DM633 latch

## Operation
- All outputs are registered; on reset: state IDLE, every output 0, o_raddr 0.
- States: IDLE, FETCH, LOAD, SHIFT, LATCH, DONE.
- IDLE: i_start=1 → FETCH with channel index = c_channels-1. i_start ignored in every other state.
- FETCH (1 cycle): o_ren=1, o_raddr=index → LOAD.
- LOAD (1 cycle): o_ren=0; i_rdata captured into a c_bps shift register; bit counter = c_bps-1 → SHIFT.
- SHIFT: per bit, c_clkdiv cycles with o_dck=0 and o_dai=current bit, then c_clkdiv cycles with o_dck=1 and o_dai unchanged. Bits go MSB first. After bit 0's high phase: index=0 → LATCH, otherwise index-1 → FETCH.
- Channel order is descending (c_channels-1 first, 0 last), so channel 0 ends nearest the FPGA in the chain.
- LATCH: o_dck=0, o_lat=1 for c_lat_w cycles → DONE.
- DONE (1 cycle): o_done=1, o_busy=0 → IDLE.
- o_raddr holds its last driven value outside FETCH; o_dai holds its last value outside SHIFT.
- Reset asserted mid-frame: immediate return to IDLE with all outputs 0. No partial latch pulse is produced.

## Timing
- Framebuffer read latency: exactly 1 cycle (o_ren in FETCH, data used in LOAD).
- Per channel: 2 + 2*c_bps*c_clkdiv cycles. With defaults: 98 cycles.
- Frame length, first FETCH through last LATCH cycle: c_channels*(2+2*c_bps*c_clkdiv) + c_lat_w.
- Data setup to DCK rise: c_clkdiv cycles. Hold after DCK rise: c_clkdiv cycles, or to the next DAI update.
- DCK is low for at least 2 cycles between words (FETCH and LOAD). This gap is legal for the DM633.
- o_busy rises the cycle after i_start is sampled. o_done rises the cycle after the last o_lat cycle.
- Earliest accepted re-start: i_start high in the first IDLE cycle after DONE.

## Configuration
- DM633_AUTOREFRESH_EN defined: IDLE moves to FETCH unconditionally, giving continuous refresh and ignoring i_start. The first frame starts the cycle after reset release. o_done still pulses once per frame.
- DM633_AUTOREFRESH_EN undefined: a frame starts only on i_start in IDLE.

## Test plan
Bench parameters: c_ledboards=1, c_clkdiv=1, c_lat_w=2; macro undefined unless stated.
- Reset, then hold i_start=0 for 50 cycles → all outputs stay 0; o_ren never asserts.
- Framebuffer ch31=12'hC00, others 0; one i_start pulse → first 12 DAI bits sampled on DCK rises are 1,1,0,0,…,0; 384 DCK rises total; frame length 834 cycles; exactly one 2-cycle o_lat pulse, then one o_done pulse.
- Read port check → o_raddr goes 31,30,…,0, each with a single-cycle o_ren; the captured word equals memory contents (ch1=1 shifts as 000000000001).
- i_start held high throughout a frame → exactly one frame runs; the next frame starts on the first IDLE cycle after DONE.
- Reset asserted at cycle 400 of a frame → outputs go 0 immediately with no o_lat or o_done; after reset release, i_start runs a full 834-cycle frame.
- DM633_AUTOREFRESH_EN defined, i_start tied 0 → back-to-back frames; o_done pulses every 836 cycles (834-cycle frame plus the DONE and IDLE cycles).
